// File: rtl/alu_op_issuer_if.sv
// Request/response handshake bundle for the ALU op issuer.
// master = requester side, slave = issuer side.
interface alu_op_issuer_if #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [OPW-1:0]   req_opcode;
  logic [WIDTH-1:0] req_op1;
  logic [WIDTH-1:0] req_op2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [OPW-1:0]   rsp_opcode;
  logic [WIDTH:0]   rsp_result;

  modport master (
    output req_valid, req_opcode, req_op1, req_op2,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_opcode, rsp_result
  );

  modport slave (
    input  req_valid, req_opcode, req_op1, req_op2,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_opcode, rsp_result
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Queues ALU requests, issues them one at a time to a fixed-latency ALU
// and returns each captured result over a valid/ready response channel.
// Ports: clk, rst (sync, active-high), bus (req/rsp handshakes),
//   alu_opcode_o/alu_op1_o/alu_op2_o (registered ALU drive),
//   alu_result_i (ALU result, MSB = carry/flag), busy_o, op_count_o.
module alu_op_issuer #(
  parameter int WIDTH   = 4,
  parameter int OPW     = 3,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_issuer_if.slave   bus,
  output logic [OPW-1:0]   alu_opcode_o,
  output logic [WIDTH-1:0] alu_op1_o,
  output logic [WIDTH-1:0] alu_op2_o,
  input  logic [WIDTH:0]   alu_result_i,
  output logic             busy_o,
  output logic [7:0]       op_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef struct packed {
    logic [OPW-1:0]   opc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  req_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             full, empty, push, pop;
  req_t             head;

  state_e           state_q;
  logic [CW-1:0]    lat_q;
  logic [OPW-1:0]   alu_opc_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             rsp_valid_q;
  logic [OPW-1:0]   rsp_opc_q;
  logic [WIDTH:0]   rsp_res_q;
  logic [7:0]       op_cnt_q;

  assign full  = (fill_q == (AW+1)'(DEPTH));
  assign empty = (fill_q == '0);
  // Pop only from IDLE; since pop needs a non-empty count taken
  // before this edge's push, an entry can never fall through.
  assign push  = bus.req_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{
        opc: bus.req_opcode,
        a:   bus.req_op1,
        b:   bus.req_op2
      };
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      alu_opc_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_opc_q   <= '0;
      rsp_res_q   <= '0;
      op_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            alu_opc_q <= head.opc;
            alu_a_q   <= head.a;
            alu_b_q   <= head.b;
            lat_q     <= CW'(ALU_LAT - 1);
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_q == '0) begin
            rsp_res_q   <= alu_result_i;
            rsp_opc_q   <= alu_opc_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_cnt_q    <= op_cnt_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = !full;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_opcode = rsp_opc_q;
  assign bus.rsp_result = rsp_res_q;
  assign alu_opcode_o   = alu_opc_q;
  assign alu_op1_o      = alu_a_q;
  assign alu_op2_o      = alu_b_q;
  assign busy_o         = (state_q != IDLE) || !empty;
  assign op_count_o     = op_cnt_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: one instance with ALU_LAT=1 and a
// stub ALU, one with ALU_LAT=3 whose ALU result is driven directly.
module tb_alu_op_issuer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  alu_op_issuer_if bus1 ();
  alu_op_issuer_if bus3 ();

  logic [2:0] opc1, opc3;
  logic [3:0] a1, b1, a3, b3;
  logic [4:0] res1, res3;
  logic       busy1, busy3;
  logic [7:0] cnt1, cnt3;

  function automatic logic [4:0] stub(logic [2:0] op, logic [3:0] a,
                                      logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {1'b0, b};
    endcase
  endfunction

  assign res1 = stub(opc1, a1, b1);

  alu_op_issuer #(.ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .alu_opcode_o(opc1), .alu_op1_o(a1), .alu_op2_o(b1),
    .alu_result_i(res1), .busy_o(busy1), .op_count_o(cnt1)
  );

  alu_op_issuer #(.ALU_LAT(3)) u3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .alu_opcode_o(opc3), .alu_op1_o(a3), .alu_op2_o(b3),
    .alu_result_i(res3), .busy_o(busy3), .op_count_o(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b);
    int n = 0;
    bus1.req_valid  = 1'b1;
    bus1.req_opcode = op;
    bus1.req_op1    = a;
    bus1.req_op2    = b;
    while (!bus1.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("push_timeout", 32'(bus1.req_ready), 1);
    tick();
    bus1.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [2:0] op, input logic [4:0] r);
    int n = 0;
    bus1.rsp_ready = 1'b1;
    while (!bus1.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_valid", 32'(bus1.rsp_valid), 1);
    chk("rsp_result", 32'(bus1.rsp_result), 32'(r));
    chk("rsp_opcode", 32'(bus1.rsp_opcode), 32'(op));
    tick();
    bus1.rsp_ready = 1'b0;
  endtask

  logic [7:0] exp_q [$];

  initial begin
    bus1.req_valid = 0; bus1.req_opcode = 0;
    bus1.req_op1 = 0; bus1.req_op2 = 0; bus1.rsp_ready = 0;
    bus3.req_valid = 0; bus3.req_opcode = 0;
    bus3.req_op1 = 0; bus3.req_op2 = 0; bus3.rsp_ready = 0;
    res3 = 5'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_rsp_valid", 32'(bus1.rsp_valid), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_req_ready", 32'(bus1.req_ready), 1);
    chk("rst_alu_op1", 32'(a1), 0);
    chk("rst_op_count", 32'(cnt1), 0);
    chk("rst_rsp_result", 32'(bus1.rsp_result), 0);

    // single op, 2 edges accept-to-response
    push(3'b000, 4'b1010, 4'b1010);
    bus1.rsp_ready = 1'b1;
    tick();
    chk("t1_alu_op1", 32'(a1), 32'hA);
    chk("t1_alu_op2", 32'(b1), 32'hA);
    chk("t1_no_rsp_yet", 32'(bus1.rsp_valid), 0);
    tick();
    chk("t1_rsp_valid", 32'(bus1.rsp_valid), 1);
    chk("t1_rsp_result", 32'(bus1.rsp_result), 32'h14);
    chk("t1_rsp_opcode", 32'(bus1.rsp_opcode), 0);
    tick();
    chk("t1_op_count", 32'(cnt1), 1);
    chk("t1_rsp_drop", 32'(bus1.rsp_valid), 0);

    // block in RESP, fill FIFO, check backpressure
    bus1.rsp_ready = 1'b0;
    push(3'b000, 4'd7, 4'd8);
    tick();
    tick();
    chk("t2_rsp_valid", 32'(bus1.rsp_valid), 1);
    chk("t2_rsp_result", 32'(bus1.rsp_result), 32'h0F);
    for (int i = 1; i <= 4; i++) push(3'b000, 4'(i), 4'(i));
    chk("t2_full", 32'(bus1.req_ready), 0);
    chk("t2_busy", 32'(busy1), 1);
    bus1.req_valid  = 1'b1;
    bus1.req_opcode = 3'b011;
    bus1.req_op1    = 4'd5;
    bus1.req_op2    = 4'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_valid", 32'(bus1.rsp_valid), 1);
      chk("bp_result", 32'(bus1.rsp_result), 32'h0F);
      chk("bp_opcode", 32'(bus1.rsp_opcode), 0);
      chk("bp_alu_op1", 32'(a1), 7);
      chk("bp_op_count", 32'(cnt1), 1);
      chk("bp_req_ready", 32'(bus1.req_ready), 0);
    end
    bus1.rsp_ready = 1'b1;
    tick();
    bus1.rsp_ready = 1'b0;
    chk("t2_accept_cnt", 32'(cnt1), 2);
    chk("t2_still_full", 32'(bus1.req_ready), 0);
    tick();
    chk("t2_pop_op1", 32'(a1), 1);
    chk("t2_ready_rise", 32'(bus1.req_ready), 1);
    tick();
    bus1.req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) get_rsp(3'b000, 5'(2 * i));
    get_rsp(3'b011, 5'd5);
    chk("t2_op_count", 32'(cnt1), 7);

    // ALU_LAT=3: only the value at the 3rd edge is captured
    bus3.rsp_ready  = 1'b0;
    bus3.req_valid  = 1'b1;
    bus3.req_opcode = 3'b010;
    bus3.req_op1    = 4'hC;
    bus3.req_op2    = 4'hA;
    tick();
    bus3.req_valid = 1'b0;
    tick();
    chk("l3_issue_op1", 32'(a3), 32'hC);
    res3 = 5'h1F;
    tick();
    chk("l3_e2_valid", 32'(bus3.rsp_valid), 0);
    chk("l3_e2_op1", 32'(a3), 32'hC);
    tick();
    chk("l3_e3_valid", 32'(bus3.rsp_valid), 0);
    chk("l3_e3_op2", 32'(b3), 32'hA);
    chk("l3_e3_opc", 32'(opc3), 2);
    res3 = 5'h08;
    tick();
    chk("l3_rsp_valid", 32'(bus3.rsp_valid), 1);
    chk("l3_rsp_result", 32'(bus3.rsp_result), 32'h08);
    chk("l3_rsp_opcode", 32'(bus3.rsp_opcode), 2);

    // reset while in WAIT with two entries queued
    for (int i = 1; i <= 4; i++) push(3'b000, 4'(i), 4'(i));
    bus1.rsp_ready = 1'b1;
    tick();
    bus1.rsp_ready = 1'b0;
    tick();
    chk("mr_wait_op1", 32'(a1), 2);
    chk("mr_wait_busy", 32'(busy1), 1);
    chk("mr_wait_valid", 32'(bus1.rsp_valid), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_rsp_valid", 32'(bus1.rsp_valid), 0);
    chk("mr_busy", 32'(busy1), 0);
    chk("mr_alu_op1", 32'(a1), 0);
    chk("mr_alu_opc", 32'(opc1), 0);
    chk("mr_req_ready", 32'(bus1.req_ready), 1);
    chk("mr_op_count", 32'(cnt1), 0);
    bus1.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_stale", 32'(bus1.rsp_valid), 0);
      chk("mr_idle", 32'(busy1), 0);
    end

    // 256 back-to-back ops, op_count wraps
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          exp_q.push_back(8'(i));
          push(3'(i), 4'(i >> 4), 4'(i));
        end
      end
      begin
        int got = 0;
        for (int n = 0; n < 2000 && got < 256; n++) begin
          tick();
          if (bus1.rsp_valid) begin
            logic [7:0] v;
            v = exp_q.pop_front();
            chk("wr_result", 32'(bus1.rsp_result),
                32'(stub(v[2:0], v[7:4], v[3:0])));
            chk("wr_opcode", 32'(bus1.rsp_opcode), 32'(v[2:0]));
            if (got == 255) chk("wr_cnt_255", 32'(cnt1), 255);
            got++;
          end
        end
        chk("wr_all_rsp", 32'(got), 256);
        tick();
        chk("wr_op_count", 32'(cnt1), 0);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
